// File: rtl/timer_pkg.sv
// ============================================================================
// Module : timer_pkg
// Brief  : Register map constants shared by the timer_bank slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  localparam logic [3:0] OFF_TH   = 4'h0;
  localparam logic [3:0] OFF_TL   = 4'h4;
  localparam logic [3:0] OFF_TCON = 4'h8;
  localparam logic [3:0] OFF_PSC  = 4'hC;

  localparam int TCON_EN      = 0;
  localparam int TCON_IE      = 1;
  localparam int TCON_ONESHOT = 2;
  localparam int TCON_PEND    = 3;

  localparam int CH_STRIDE = 16;
  localparam int PSC_W     = 16;

endpackage

`default_nettype wire

// File: rtl/timer_channel.sv
// ============================================================================
// Module : timer_channel
// Brief  : One up-counting timer with reload, one-shot and W1C pending flag.
//          Optional per-channel prescaler when TIMER_PRESCALE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_th_i,
  input  logic              wr_tl_i,
  input  logic              wr_tcon_i,
  input  logic              wr_psc_i,
  input  logic [31:0]       wdata_i,
  output logic [WIDTH-1:0]  th_o,
  output logic [WIDTH-1:0]  tl_o,
  output logic [3:0]        tcon_o,
  output logic [PSC_W-1:0]  psc_o,
  output logic              irq_o
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] th_q, th_d, tl_q, tl_d;
  logic             en_q, en_d, ie_q, ie_d, os_q, os_d, pend_q, pend_d;
  logic             tick, ovf;

`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc_q, psc_d, pcnt_q, pcnt_d;

  assign tick = en_q && (pcnt_q == psc_q);

  // Any reconfiguration restarts the prescale phase so the next tick is a full period away.
  always_comb begin
    psc_d = wr_psc_i ? wdata_i[PSC_W-1:0] : psc_q;
    if (!en_q || wr_tl_i || wr_tcon_i || wr_psc_i || tick) pcnt_d = '0;
    else                                                   pcnt_d = pcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc_q  <= '0;
      pcnt_q <= '0;
    end else begin
      psc_q  <= psc_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign psc_o = psc_q;
`else
  logic unused_psc;
  assign unused_psc = wr_psc_i;
  assign tick       = en_q;
  assign psc_o      = '0;
`endif

  assign ovf = tick && (tl_q == ALL_ONES);

  always_comb begin
    th_d = wr_th_i ? wdata_i[WIDTH-1:0] : th_q;

    if (wr_tl_i)   tl_d = wdata_i[WIDTH-1:0];
    else if (ovf)  tl_d = th_q;
    else if (tick) tl_d = tl_q + ONE;
    else           tl_d = tl_q;

    // A CPU write of TCON overrides the one-shot auto-disable; pend set beats the W1C clear.
    en_d   = en_q & ~(ovf & os_q);
    ie_d   = ie_q;
    os_d   = os_q;
    if (wr_tcon_i) begin
      en_d = wdata_i[TCON_EN];
      ie_d = wdata_i[TCON_IE];
      os_d = wdata_i[TCON_ONESHOT];
    end
    pend_d = ovf | (pend_q & ~(wr_tcon_i & wdata_i[TCON_PEND]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      os_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      en_q   <= en_d;
      ie_q   <= ie_d;
      os_q   <= os_d;
      pend_q <= pend_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = {pend_q, os_q, ie_q, en_q};
  assign irq_o  = pend_q & ie_q;

endmodule

`default_nettype wire

// File: rtl/timer_bank.sv
// ============================================================================
// Module : timer_bank
// Brief  : Memory-mapped bank of NUM_TIMERS timers with combined interrupt.
//          Build option: TIMER_PRESCALE_EN adds per-channel PSC registers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_bank
  import timer_pkg::*;
#(
  parameter int          NUM_TIMERS = 4,
  parameter int          WIDTH      = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h40000100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_i,
  input  logic                  wr_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic [NUM_TIMERS-1:0] irq_vec_o,
  output logic                  irqout_o
);

  localparam logic [31:0] WIN_SIZE = 32'(CH_STRIDE * NUM_TIMERS);

  logic [31:0]           offset;
  logic                  in_win, is_sum;
  logic [NUM_TIMERS-1:0] pend_vec;

  logic [WIDTH-1:0] th_a   [NUM_TIMERS];
  logic [WIDTH-1:0] tl_a   [NUM_TIMERS];
  logic [3:0]       tcon_a [NUM_TIMERS];
  logic [PSC_W-1:0] psc_a  [NUM_TIMERS];

  // Addresses below the base wrap to large offsets and fall outside the window.
  assign offset = addr_i - BASE_ADDR;
  assign in_win = offset < WIN_SIZE;
  assign is_sum = offset == WIN_SIZE;

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_ch
    logic sel;
    assign sel = wr_i && in_win && (offset[6:4] == 3'(n));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_th_i   (sel && (offset[3:0] == OFF_TH)),
      .wr_tl_i   (sel && (offset[3:0] == OFF_TL)),
      .wr_tcon_i (sel && (offset[3:0] == OFF_TCON)),
      .wr_psc_i  (sel && (offset[3:0] == OFF_PSC)),
      .wdata_i   (wdata_i),
      .th_o      (th_a[n]),
      .tl_o      (tl_a[n]),
      .tcon_o    (tcon_a[n]),
      .psc_o     (psc_a[n]),
      .irq_o     (irq_vec_o[n])
    );

    assign pend_vec[n] = tcon_a[n][TCON_PEND];
  end

  assign irqout_o = |irq_vec_o;

  always_comb begin
    rdata_o = '0;
    if (rd_i) begin
      if (is_sum) begin
        rdata_o = 32'(pend_vec);
      end else if (in_win) begin
        for (int n = 0; n < NUM_TIMERS; n++) begin
          if (offset[6:4] == 3'(n)) begin
            case (offset[3:0])
              OFF_TH:   rdata_o = 32'(th_a[n]);
              OFF_TL:   rdata_o = 32'(tl_a[n]);
              OFF_TCON: rdata_o = {28'd0, tcon_a[n]};
              OFF_PSC:  rdata_o = {16'd0, psc_a[n]};
              default:  rdata_o = '0;
            endcase
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
